// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter.
// 640x480 at 8 bpp (RGB332), two pixels per 16-bit framebuffer word.
package vga_pkg;

    localparam int H_TOTAL        = 800;
    localparam int V_TOTAL        = 525;
    localparam int H_ACTIVE_START = 144;
    localparam int H_ACTIVE_END   = 784;
    localparam int V_ACTIVE_START = 41;
    localparam int V_ACTIVE_END   = 521;
    localparam int WORDS_PER_LINE = 320;
    localparam int PREFETCH_H     = 140;

    typedef logic [7:0] pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous word FIFO between the framebuffer read port and the pixel
// output. Flush takes priority over push and pop; head is the oldest word.
module pixel_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic              clk_25,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head,
    output logic [LVL_W-1:0]  level,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; wrap is free because depth is a power of 2.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      level <= level + LVL_W'(1);
            else if (!do_push && do_pop) level <= level - LVL_W'(1);
        end
    end

    // Word storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk_25) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port framebuffer arbiter: the display line prefetch owns the memory
// whenever it has FIFO credit, every other slot goes to the writer.
// Optional build macro VGA_ARB_STATS_EN adds the wr_wait_cnt stall counter.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
    parameter int PREFETCH_H     = vga_pkg::PREFETCH_H,
    parameter int V_ACTIVE_START = vga_pkg::V_ACTIVE_START,
    parameter int V_ACTIVE_END   = vga_pkg::V_ACTIVE_END
) (
    input  logic              clk_25,
    input  logic              reset_n,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              bright,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        pixel,
    output logic              underflow
`ifdef VGA_ARB_STATS_EN
    ,
    output logic [15:0]       wr_wait_cnt
`endif
);

    localparam int CNT_W = $clog2(WORDS_PER_LINE + 1);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [CNT_W-1:0]  fetch_cnt;
    logic [ADDR_W-1:0] line_base;
    logic              byte_sel;
    logic              rd_vld_p1;
    logic              underflow_q;
    logic              line_trig;
    logic              frame_start;
    logic              credit_ok;
    logic              rd_issue;
    logic              wr_grant;
    logic              pix_vld;
    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_empty;
    pixel_t            pix_lo;
    pixel_t            pix_hi;

    assign frame_start = (h_count == 10'd0) && (v_count == 10'd0);
    assign line_trig   = (h_count == 10'(PREFETCH_H))
                      && (v_count >= 10'(V_ACTIVE_START))
                      && (v_count <  10'(V_ACTIVE_END));
    // The in-flight read already owns a FIFO slot, so count it as used.
    assign credit_ok   = ((LVL_W+1)'(fifo_level) + (LVL_W+1)'(rd_vld_p1))
                      < (LVL_W+1)'(FIFO_DEPTH);

    // Fetch state register.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and display read decision; the trigger cycle never reads.
    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
        if (line_trig) begin
            state_d = FETCH;
        end else if (state_q == FETCH && credit_ok
                     && fetch_cnt < CNT_W'(WORDS_PER_LINE)) begin
            rd_issue = 1'b1;
            if (fetch_cnt == CNT_W'(WORDS_PER_LINE - 1)) state_d = IDLE;
        end
    end

    // Memory port mux: display read first, writer gets every other slot.
    always_comb begin
        wr_grant  = reset_n && wr_req && !rd_issue;
        wr_ack    = wr_grant;
        mem_en    = rd_issue || wr_grant;
        mem_we    = wr_grant;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_issue) begin
            mem_addr = line_base + ADDR_W'(fetch_cnt);
        end else if (wr_grant) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    // Line fetch position and per-frame line base address.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= '0;
            line_base <= '0;
        end else begin
            if (line_trig)     fetch_cnt <= '0;
            else if (rd_issue) fetch_cnt <= fetch_cnt + CNT_W'(1);
            if (frame_start)
                line_base <= '0;
            else if (rd_issue && fetch_cnt == CNT_W'(WORDS_PER_LINE - 1))
                line_base <= line_base + ADDR_W'(WORDS_PER_LINE);
        end
    end

    // Read return stage: data arrives the cycle after the read was issued.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) rd_vld_p1 <= 1'b0;
        else          rd_vld_p1 <= rd_issue;
    end

    pixel_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_25    (clk_25),
        .reset_n   (reset_n),
        .push      (rd_vld_p1),
        .pop       (pix_vld && byte_sel),
        .flush     (line_trig),
        .push_data (mem_rdata),
        .head      (fifo_head),
        .level     (fifo_level),
        .empty     (fifo_empty)
    );

    assign pix_vld = bright && !fifo_empty;
    assign pix_lo  = fifo_head[7:0];
    assign pix_hi  = fifo_head[15:8];
    assign pixel   = pix_vld ? (byte_sel ? pix_hi : pix_lo) : 8'h00;
    assign underflow = underflow_q;

    // Byte select walks low then high byte; sticky underflow on a starved beam.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            byte_sel    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (line_trig)    byte_sel <= 1'b0;
            else if (pix_vld) byte_sel <= ~byte_sel;
            if (bright && fifo_empty) underflow_q <= 1'b1;
        end
    end

`ifdef VGA_ARB_STATS_EN
    // Saturating count of writer stall cycles, restarted every frame.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n)
            wr_wait_cnt <= '0;
        else if (frame_start)
            wr_wait_cnt <= '0;
        else if (wr_req && !wr_grant && wr_wait_cnt != 16'hFFFF)
            wr_wait_cnt <= wr_wait_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: table vectors for the idle/blanking
// arbitration, hand sequences for reset and underflow, and randomized writer
// traffic over full active lines checked against a line-level reference model.
module tb_vga_mem_arbiter;

    logic        clk_25  = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  h_count = '0;
    logic [9:0]  v_count = '0;
    logic        bright  = 1'b0;
    logic        wr_req  = 1'b0;
    logic [17:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [7:0]  pixel;
    logic        underflow;
`ifdef VGA_ARB_STATS_EN
    logic [15:0] wr_wait_cnt;
    int          wait_model = 0;
`endif

    int checks = 0;
    int errors = 0;
    int lb_model = 0;
    logic [15:0] seed = 16'h5A3C;

    bit [15:0]   fb      [4096];
    bit          fb_wr   [4096];
    logic [15:0] sh_data [4096];
    bit          sh_flag [4096];

    vga_mem_arbiter dut (
        .clk_25    (clk_25),
        .reset_n   (reset_n),
        .h_count   (h_count),
        .v_count   (v_count),
        .bright    (bright),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pixel     (pixel),
        .underflow (underflow)
`ifdef VGA_ARB_STATS_EN
        ,
        .wr_wait_cnt (wr_wait_cnt)
`endif
    );

    always #20 clk_25 = ~clk_25;

    function automatic logic [15:0] pat(input int a);
        return 16'(a * 40503) ^ seed;
    endfunction

    function automatic logic [15:0] word_exp(input int a);
        int i;
        i = a & 4095;
        return sh_flag[i] ? sh_data[i] : pat(i);
    endfunction

    // Framebuffer stub: registered read data, writes land at the clock edge.
    always @(posedge clk_25) begin
        if (mem_en) begin
            if (mem_we) begin
                fb[mem_addr[11:0]]    <= mem_wdata;
                fb_wr[mem_addr[11:0]] <= 1'b1;
            end else begin
                mem_rdata <= fb_wr[mem_addr[11:0]] ? fb[mem_addr[11:0]]
                                                   : pat(int'(mem_addr[11:0]));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet_port();
        chk("quiet_mem_en", 32'(mem_en), 32'd0);
        chk("quiet_mem_we", 32'(mem_we), 32'd0);
        chk("quiet_wr_ack", 32'(wr_ack), 32'd0);
        chk("quiet_mem_addr", 32'(mem_addr), 32'd0);
        chk("quiet_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("quiet_pixel", 32'(pixel), 32'd0);
        chk("quiet_underflow", 32'(underflow), 32'd0);
    endtask

    // One full line of the reference model: sequential addresses from the
    // line base, byte stream low-then-high, writer served in every free slot.
    task automatic run_line(input int v);
        int  rd_k;
        int  bi;
        bit  acked;
        logic [15:0] w;
        logic [7:0]  ep;
        rd_k  = 0;
        bi    = 0;
        acked = 1'b0;
        for (int h = 0; h < 800; h++) begin
            @(negedge clk_25);
            h_count = 10'(h);
            v_count = 10'(v);
            bright  = (h >= 144 && h < 784);
            if (!wr_req || acked) begin
                wr_req  = ($urandom_range(3) != 0);
                wr_addr = 18'(2048 + $urandom_range(2047));
                wr_data = 16'($urandom);
            end
            acked = 1'b0;
            #5;
            if (mem_en && !mem_we) begin
                chk("rd_count_bound", 32'(rd_k < 320), 32'd1);
                chk("rd_addr", 32'(mem_addr), 32'(lb_model + rd_k));
                rd_k++;
                chk("outstanding_le_depth", 32'((rd_k - bi / 2) <= 8), 32'd1);
            end
            if (wr_req) begin
                if (wr_ack) begin
                    chk("wr_we", 32'(mem_we), 32'd1);
                    chk("wr_addr", 32'(mem_addr), 32'(wr_addr));
                    chk("wr_data", 32'(mem_wdata), 32'(wr_data));
                    sh_data[wr_addr[11:0]] = wr_data;
                    sh_flag[wr_addr[11:0]] = 1'b1;
                    acked = 1'b1;
                end else begin
                    chk("wr_blocked_only_by_read", 32'(mem_en && !mem_we), 32'd1);
`ifdef VGA_ARB_STATS_EN
                    wait_model++;
`endif
                end
            end else begin
                chk("no_req_no_ack", 32'(wr_ack), 32'd0);
            end
            if (bright) begin
                w  = word_exp(lb_model + bi / 2);
                ep = (bi % 2 == 1) ? w[15:8] : w[7:0];
                chk("pixel", 32'(pixel), 32'(ep));
                bi++;
            end else begin
                chk("pixel_blank", 32'(pixel), 32'd0);
            end
        end
        chk("line_reads", 32'(rd_k), 32'd320);
        chk("line_pixels", 32'(bi), 32'd640);
        chk("line_underflow", 32'(underflow), 32'd0);
`ifdef VGA_ARB_STATS_EN
        chk("wr_wait_cnt", 32'(wr_wait_cnt), 32'(wait_model > 65535 ? 65535 : wait_model));
`endif
        lb_model += 320;
    endtask

    task automatic frame_start_cycle();
        @(negedge clk_25);
        h_count = '0;
        v_count = '0;
        bright  = 1'b0;
        wr_req  = 1'b0;
        lb_model = 0;
`ifdef VGA_ARB_STATS_EN
        wait_model = 0;
`endif
        #5;
        chk("fs_mem_en", 32'(mem_en), 32'd0);
    endtask

    typedef struct {
        logic [9:0]  v;
        logic [9:0]  h;
        logic        req;
        logic [17:0] addr;
        logic [15:0] data;
        logic        ack;
        logic        en;
        logic        we;
        logic [17:0] exp_addr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{10'd5,   10'd10,  1'b1, 18'h00A55, 16'hBEEF, 1'b1, 1'b1, 1'b1, 18'h00A55};
        tbl[1] = '{10'd5,   10'd11,  1'b0, 18'h00A56, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h00000};
        tbl[2] = '{10'd5,   10'd140, 1'b1, 18'h3FFFF, 16'h1234, 1'b1, 1'b1, 1'b1, 18'h3FFFF};
        tbl[3] = '{10'd40,  10'd140, 1'b1, 18'h00800, 16'h0001, 1'b1, 1'b1, 1'b1, 18'h00800};
        tbl[4] = '{10'd521, 10'd140, 1'b1, 18'h00801, 16'h0002, 1'b1, 1'b1, 1'b1, 18'h00801};
        tbl[5] = '{10'd41,  10'd140, 1'b1, 18'h00802, 16'h0003, 1'b1, 1'b1, 1'b1, 18'h00802};
        tbl[6] = '{10'd41,  10'd141, 1'b1, 18'h00803, 16'h0004, 1'b0, 1'b1, 1'b0, 18'h00000};
        tbl[7] = '{10'd41,  10'd142, 1'b0, 18'h00804, 16'h0005, 1'b0, 1'b1, 1'b0, 18'h00001};

        // Reset state: outputs quiet even with a request and bright raised.
        @(negedge clk_25);
        wr_req  = 1'b1;
        wr_addr = 18'h00123;
        wr_data = 16'hA5A5;
        v_count = 10'd5;
        h_count = 10'd10;
        bright  = 1'b1;
        #5;
        chk_quiet_port();
        @(negedge clk_25);
        wr_req = 1'b0;
        bright = 1'b0;
        reset_n = 1'b1;

        // Idle/blanking arbitration, trigger edges and first fetch cycles.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_25);
            v_count = tbl[i].v;
            h_count = tbl[i].h;
            wr_req  = tbl[i].req;
            wr_addr = tbl[i].addr;
            wr_data = tbl[i].data;
            bright  = 1'b0;
            #5;
            chk($sformatf("tbl%0d_ack", i), 32'(wr_ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_en", i), 32'(mem_en), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
            if (tbl[i].en)
                chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].exp_addr));
            if (tbl[i].we)
                chk($sformatf("tbl%0d_wdata", i), 32'(mem_wdata), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_pixel", i), 32'(pixel), 32'd0);
            if (tbl[i].ack) begin
                sh_data[tbl[i].addr[11:0]] = tbl[i].data;
                sh_flag[tbl[i].addr[11:0]] = 1'b1;
            end
        end

        // Reset mid-FETCH at h_count=145: everything drops immediately.
        for (int h = 143; h <= 145; h++) begin
            @(negedge clk_25);
            h_count = 10'(h);
            v_count = 10'd41;
            bright  = (h >= 144);
            wr_req  = (h == 145);
            wr_addr = 18'h00900;
            wr_data = 16'h7777;
        end
        #5;
        reset_n = 1'b0;
        #1;
        chk_quiet_port();
        @(negedge clk_25);
        h_count = 10'd146;
        bright  = 1'b0;
        #5;
        chk_quiet_port();
        wr_req = 1'b0;
        @(negedge clk_25);
        reset_n = 1'b1;

        // Randomized writer against full active lines, frame wrap in between.
        frame_start_cycle();
        run_line(41);
        run_line(42);
        frame_start_cycle();
        run_line(41);
        @(negedge clk_25);
        wr_req = 1'b0;

        // Starved beam: bright with nothing fetched.
        @(negedge clk_25);
        v_count = 10'd5;
        h_count = 10'd200;
        bright  = 1'b1;
        #5;
        chk("starve_pixel0", 32'(pixel), 32'd0);
        chk("starve_uf_before_edge", 32'(underflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_25);
            h_count = 10'(201 + k);
            bright  = (k < 2);
            #5;
            chk("starve_pixel", 32'(pixel), 32'd0);
            chk("underflow_sticky", 32'(underflow), 32'd1);
        end
        #5;
        reset_n = 1'b0;
        #1;
        chk("underflow_cleared_by_reset", 32'(underflow), 32'd0);
        @(negedge clk_25);
        reset_n = 1'b1;

        // Every accepted write must be in the framebuffer stub.
        for (int a = 0; a < 4096; a++) begin
            if (sh_flag[a]) chk("mem_written", 32'(fb[a]), 32'(sh_data[a]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Shares one single-port framebuffer SRAM between two requesters: the display pixel fetch (hard real-time) and a drawing/CPU writer.
- Fetches each active line ahead of the beam into a small pixel FIFO, driven by h_count/v_count/bright from the VGA timing unit.
- Grants every memory slot the display does not need to the writer.
- Framebuffer is 640x480 at 8 bpp (RGB332), two pixels per 16-bit word, 320 words per line.

Parameters:
ADDR_W, 18, framebuffer word address width
DATA_W, 16, memory word width (two 8-bit pixels; low byte displayed first)
FIFO_DEPTH, 8, pixel FIFO depth in words (power of 2)
WORDS_PER_LINE, 320, words fetched per active line
PREFETCH_H, 140, h_count value that starts the line fetch
V_ACTIVE_START, 41, first active v_count
V_ACTIVE_END, 521, first v_count after the active region

Ports:
clk_25  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
h_count  in  10  horizontal count from the timing unit
v_count  in  10  vertical count from the timing unit
bright  in  1  active-video flag from the timing unit
wr_req  in  1  writer request; held until wr_ack
wr_addr  in  ADDR_W  writer word address
wr_data  in  DATA_W  writer word data
wr_ack  out  1  one-cycle write-grant pulse
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid 1 cycle after the read cycle
pixel  out  8  RGB332 pixel; 0 when bright=0
underflow  out  1  sticky: bright was high while the FIFO was empty

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk_25.
- Reset values:
  - all outputs 0; FSM IDLE.
  - fetch_cnt=0, line_base=0, byte_sel=0, FIFO empty, in-flight flag 0.
- Frame start (h_count==0 && v_count==0): line_base<=0.
- Line trigger: h_count==PREFETCH_H and V_ACTIVE_START <= v_count < V_ACTIVE_END.
  - FIFO flushed, fetch_cnt<=0, byte_sel<=0, FSM->FETCH.
  - A trigger while already in FETCH restarts the fetch the same way.
- FSM:
  - IDLE: every cycle is available to the writer.
  - FETCH: a display read is issued when fifo_level + inflight < FIFO_DEPTH and fetch_cnt < WORDS_PER_LINE.
    - Read drives mem_en=1, mem_we=0, mem_addr = line_base + fetch_cnt; fetch_cnt increments.
    - When the last read is issued: FSM->IDLE, line_base += WORDS_PER_LINE.
- Read return: mem_rdata is pushed to the FIFO in the cycle after the read.
  - inflight (0/1) counts in credit accounting, so the FIFO never overflows.
- Arbitration, per cycle: display read has absolute priority. Otherwise, if wr_req=1:
  - mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1 in that same cycle.
  - The writer must hold its request until it sees wr_ack and may drop or re-raise it the next cycle.
- Writer never starves: the display needs 1 slot per 2 clocks once the FIFO fills, and none during blanking.
- Pixel output: combinational from the FIFO head.
  - pixel = bright ? (byte_sel ? head[15:8] : head[7:0]) : 0.
  - On each bright cycle byte_sel toggles; the FIFO pops when byte_sel=1.
- Underflow: bright=1 with the FIFO empty gives pixel=0, no pop, byte_sel does not toggle, underflow<=1.
  - underflow is cleared only by reset.
- Simultaneous push and pop: both are allowed in the same cycle; level unchanged.
- Reset mid-operation: an in-flight read is discarded; no wr_ack is issued.

Optional Feature:
VGA_ARB_STATS_EN
- Defined:
  - Adds output wr_wait_cnt[15:0]: a saturating count of cycles with wr_req=1 and wr_ack=0.
  - Reset value 0; cleared at each frame start.
- Undefined: the port and the counter are absent; arbitration is identical.

Decomposition:
- Package vga_pkg: timing constants (H_TOTAL, active start/end values), WORDS_PER_LINE, pixel typedef (8-bit RGB332), FSM state enum {IDLE, FETCH}.
- Sub-module pixel_fifo: synchronous FIFO, DATA_W x FIFO_DEPTH, with push/pop/flush, head data, and level outputs.

Test Plan:
- Reset mid-FETCH (assert reset_n low at h_count=145) -> all outputs 0, FIFO empty, FSM IDLE immediately (async).
- First active line (v_count=41, h_count=140): reads to addrs 0..319 issued in order, never more than 8 outstanding plus buffered; pixel sequence equals low byte then high byte of each word; underflow stays 0.
- Line v_count=42: first read address 320; at frame start line_base returns to 0 and line 41 again reads from address 0.
- wr_req held continuously during FETCH -> wr_ack only in cycles without a display read; every write lands at wr_addr/wr_data; no display read is lost.
- wr_req during blanking (v_count=5) -> wr_ack in the same cycle as the request; mem_we=1.
- Force the memory stub to hold off reads (FIFO starved) while bright=1 -> pixel=0 and underflow=1 stays set until reset; with VGA_ARB_STATS_EN, wr_wait_cnt saturates at 0xFFFF under a constant stall.
